// File: rtl/pc_fetch_unit.sv
// Datapath fetch stage: PC, IR and ALUOut registers, next-PC selection and
// conditional branch resolution for the multicycle controller.
module pc_fetch_unit #(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter int unsigned        CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_write,
   input  logic              pc_write_cond,
   input  logic              branch_type,
   input  logic [1:0]        pc_source,
   input  logic              ir_write,
   input  logic [31:0]       mem_rdata,
   input  logic [31:0]       alu_result,
   input  logic              alu_zero,
   input  logic [31:0]       reg_a,
   input  logic [31:0]       reg_b,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       instr,
   output logic [31:0]       alu_out_q,
   output logic              branch_taken,
   output logic [CNT_W-1:0]  fetch_count
);

   localparam int unsigned DATA_W = 32;

   typedef enum logic [3:0] {
      BR_EQ = 4'b0000,
      BR_NE = 4'b0001,
      BR_LT = 4'b0010,
      BR_GE = 4'b0011
   } br_op_e;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0] alu_out_d;
   logic              branch_taken_q, branch_taken_d;
   logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

   logic [ADDR_W-1:0] jump_target;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] src_pc;
   logic              br_cond;

   // Jump keeps the upper PC bits when the PC is wider than the 26-bit field
   if (ADDR_W > 26) begin : g_jmp_wide
      assign jump_target = {pc_q[ADDR_W-1:26], instr_q[25:0]};
   end else begin : g_jmp_narrow
      assign jump_target = instr_q[ADDR_W-1:0];
   end

   assign branch_target = pc_q + ADDR_W'($signed(instr_q[15:0]));

   always_comb begin
      br_cond = 1'b0;
      case (br_op_e'(instr_q[29:26]))
         BR_EQ:   br_cond = (reg_a == reg_b);
         BR_NE:   br_cond = (reg_a != reg_b);
         BR_LT:   br_cond = ($signed(reg_a) <  $signed(reg_b));
         BR_GE:   br_cond = ($signed(reg_a) >= $signed(reg_b));
         default: br_cond = 1'b0;
      endcase
   end

   always_comb begin
      src_pc = ADDR_W'(alu_result);
      case (pc_source)
         2'b00:   src_pc = ADDR_W'(alu_result);
         2'b01:   src_pc = ADDR_W'(alu_out_q);
         2'b10:   src_pc = jump_target;
         default: src_pc = ADDR_W'(reg_a);
      endcase
   end

   // Next-state: pc_write dominates pc_write_cond; branches ignore pc_source
   always_comb begin
      pc_d           = pc_q;
      instr_d        = instr_q;
      alu_out_d      = alu_result;
      branch_taken_d = 1'b0;
      fetch_count_d  = fetch_count_q;

      if (ir_write) begin
         instr_d       = mem_rdata;
         fetch_count_d = fetch_count_q + CNT_W'(1);
      end

      if (pc_write && branch_type) begin
         if (br_cond) begin
            pc_d           = branch_target;
            branch_taken_d = 1'b1;
         end
      end else if (pc_write || (pc_write_cond && alu_zero)) begin
         pc_d = src_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q           <= RESET_PC;
         instr_q        <= '0;
         alu_out_q      <= '0;
         branch_taken_q <= 1'b0;
         fetch_count_q  <= '0;
      end else begin
         pc_q           <= pc_d;
         instr_q        <= instr_d;
         alu_out_q      <= alu_out_d;
         branch_taken_q <= branch_taken_d;
         fetch_count_q  <= fetch_count_d;
      end
   end

   assign pc           = pc_q;
   assign instr        = instr_q;
   assign branch_taken = branch_taken_q;
   assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a reference model predicts the state after
// every driven edge and a monitor compares it one step after the edge.
module tb_pc_fetch_unit;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              pc_write = 1'b0, pc_write_cond = 1'b0, branch_type = 1'b0;
   logic [1:0]        pc_source = 2'b00;
   logic              ir_write = 1'b0;
   logic [31:0]       mem_rdata = '0, alu_result = '0, reg_a = '0, reg_b = '0;
   logic              alu_zero = 1'b0;
   logic [ADDR_W-1:0] pc;
   logic [31:0]       instr, alu_out_q;
   logic              branch_taken;
   logic [CNT_W-1:0]  fetch_count;

   pc_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .branch_type(branch_type), .pc_source(pc_source), .ir_write(ir_write),
      .mem_rdata(mem_rdata), .alu_result(alu_result), .alu_zero(alu_zero),
      .reg_a(reg_a), .reg_b(reg_b), .pc(pc), .instr(instr), .alu_out_q(alu_out_q),
      .branch_taken(branch_taken), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] alu;
      logic        bt;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t m;            // model state after the last predicted edge
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
      end
   endtask

   // Monitor: compare each predicted state just after its edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("pc",           pc,           e.pc);
         chk("instr",        instr,        e.instr);
         chk("alu_out_q",    alu_out_q,    e.alu);
         chk("branch_taken", 32'(branch_taken), 32'(e.bt));
         chk("fetch_count",  32'(fetch_count),  32'(e.cnt));
      end
   end

   function automatic exp_t predict(input exp_t s);
      exp_t n;
      logic cond;
      logic [31:0] mux;
      n = s;
      if (reset) begin
         n.pc = 32'h0; n.instr = 32'h0; n.alu = 32'h0; n.bt = 1'b0; n.cnt = 16'h0;
         return n;
      end
      n.alu = alu_result;
      n.bt  = 1'b0;
      if (ir_write) begin
         n.instr = mem_rdata;
         n.cnt   = s.cnt + 16'd1;
      end
      case (s.instr[29:26])
         4'd0:    cond = (reg_a == reg_b);
         4'd1:    cond = (reg_a != reg_b);
         4'd2:    cond = ($signed(reg_a) <  $signed(reg_b));
         4'd3:    cond = ($signed(reg_a) >= $signed(reg_b));
         default: cond = 1'b0;
      endcase
      case (pc_source)
         2'd0:    mux = alu_result;
         2'd1:    mux = s.alu;
         2'd2:    mux = {s.pc[31:26], s.instr[25:0]};
         default: mux = reg_a;
      endcase
      if (pc_write && branch_type) begin
         if (cond) begin
            n.pc = s.pc + {{16{s.instr[15]}}, s.instr[15:0]};
            n.bt = 1'b1;
         end
      end else if (pc_write || (pc_write_cond && alu_zero)) begin
         n.pc = mux;
      end
      return n;
   endfunction

   // Apply one cycle of stimulus, predict its effect, then wait past the monitor
   task automatic drive(input logic rst, input logic pw, input logic pwc, input logic bty,
                        input logic [1:0] src, input logic irw, input logic [31:0] mrd,
                        input logic [31:0] alur, input logic az,
                        input logic [31:0] ra, input logic [31:0] rb);
      @(negedge clk);
      reset = rst; pc_write = pw; pc_write_cond = pwc; branch_type = bty;
      pc_source = src; ir_write = irw; mem_rdata = mrd; alu_result = alur;
      alu_zero = az; reg_a = ra; reg_b = rb;
      m = predict(m);
      exp_q.push_back(m);
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
   endtask

   task automatic set_pc(input logic [31:0] v);
      drive(0, 1, 0, 0, 2'd0, 0, 32'h0, v, 0, 32'h0, 32'h0);
   endtask

   task automatic set_ir(input logic [31:0] v);
      drive(0, 0, 0, 0, 2'd0, 1, v, 32'h0, 0, 32'h0, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      m = '{pc: 32'h0, instr: 32'h0, alu: 32'h0, bt: 1'b0, cnt: 16'h0};
      drive(1, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);

      // T1: reset clears a dirty pc/instr
      set_pc(32'h55);
      set_ir(32'hFFFF_FFFF);
      drive(1, 1, 0, 0, 2'd0, 1, 32'h1234_5678, 32'h77, 0, 32'h0, 32'h0);
      chk("t1_pc", pc, 32'h0);
      chk("t1_instr", instr, 32'h0);
      chk("t1_cnt", 32'(fetch_count), 32'h0);

      // T2: ALU source and ALUOut delay
      set_pc(32'd5);
      set_pc(32'd6);
      chk("t2_pc", pc, 32'd6);
      chk("t2_aluout", alu_out_q, 32'd6);

      // T3: BEQ taken then not taken
      set_pc(32'd10);
      set_ir(32'h8000_FFFE);
      drive(0, 1, 0, 1, 2'd3, 0, 32'h0, 32'h99, 0, 32'd7, 32'd7);
      chk("t3_beq_pc", pc, 32'd8);
      chk("t3_beq_bt", 32'(branch_taken), 32'd1);
      idle();
      chk("t3_bt_pulse", 32'(branch_taken), 32'd0);
      set_pc(32'd10);
      drive(0, 1, 0, 1, 2'd0, 0, 32'h0, 32'h99, 0, 32'd7, 32'd8);
      chk("t3_nt_pc", pc, 32'd10);
      chk("t3_nt_bt", 32'(branch_taken), 32'd0);

      // T4: signed BLT and jump
      set_pc(32'd20);
      set_ir(32'h0800_0004);
      drive(0, 1, 0, 1, 2'd0, 0, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 32'd1);
      chk("t4_blt_pc", pc, 32'd24);
      set_ir(32'h0000_0123);
      drive(0, 1, 0, 0, 2'd2, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      chk("t4_jump_pc", pc, 32'h123);

      // T5: pc_write dominates pc_write_cond; cond alone needs alu_zero
      drive(0, 1, 1, 0, 2'd3, 0, 32'h0, 32'h0, 0, 32'h40, 32'h0);
      chk("t5_dom_pc", pc, 32'h40);
      drive(0, 0, 1, 0, 2'd0, 0, 32'h0, 32'h99, 0, 32'h0, 32'h0);
      chk("t5_hold_pc", pc, 32'h40);
      drive(0, 0, 1, 0, 2'd1, 0, 32'h0, 32'h5, 1, 32'h0, 32'h0);
      chk("t5_cond_pc", pc, 32'h99);

      // Random mix covering BNE/BGE/unused ops, same-edge IR+PC writes, mid resets
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ra, rb, mrd;
         ra  = $urandom();
         rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom();
         mrd = {$urandom_range(0, 3) == 0 ? 2'b00 : 2'($urandom()),
                4'($urandom_range(0, 5)), 26'($urandom())};
         drive(($urandom_range(0, 40) == 0), 1'($urandom()), 1'($urandom()),
               1'($urandom()), 2'($urandom()), 1'($urandom()), mrd,
               $urandom(), 1'($urandom()), ra, rb);
      end

      // T6: fetch counter wraps after 2^CNT_W+1 loads, then mid-sequence reset
      drive(1, 0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      for (int i = 0; i < (1 << CNT_W) + 1; i++) set_ir(32'(i));
      chk("t6_wrap", 32'(fetch_count), 32'd1);
      for (int i = 0; i < 5; i++) set_ir(32'(i));
      drive(1, 0, 0, 0, 2'd0, 1, 32'hABCD, 32'h0, 0, 32'h0, 32'h0);
      chk("t6_rst_cnt", 32'(fetch_count), 32'd0);
      set_ir(32'hCAFE);
      chk("t6_after_rst", 32'(fetch_count), 32'd1);

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
